// File: rtl/instr_pkg.sv
// Shared constants for the instruction decoder: one-hot bit positions, opcode/funct/rs codes
// and the buffered decode entry layout.
package instr_pkg;

    localparam int NUM_OPS = 55;

    // One-hot bit positions, SPECIAL group first, then I/J, REGIMM, COP0, SPECIAL2
    localparam logic [5:0] OP_ADD   = 6'd0,  OP_ADDU  = 6'd1,  OP_SUB     = 6'd2,  OP_SUBU  = 6'd3,
                           OP_AND   = 6'd4,  OP_OR    = 6'd5,  OP_XOR     = 6'd6,  OP_NOR   = 6'd7,
                           OP_SLT   = 6'd8,  OP_SLTU  = 6'd9,  OP_SLL     = 6'd10, OP_SRL   = 6'd11,
                           OP_SRA   = 6'd12, OP_SLLV  = 6'd13, OP_SRLV    = 6'd14, OP_SRAV  = 6'd15,
                           OP_JR    = 6'd16, OP_JALR  = 6'd17, OP_SYSCALL = 6'd18, OP_BREAK = 6'd19,
                           OP_MFHI  = 6'd20, OP_MTHI  = 6'd21, OP_MFLO    = 6'd22, OP_MTLO  = 6'd23,
                           OP_MULT  = 6'd24, OP_MULTU = 6'd25, OP_DIV     = 6'd26, OP_DIVU  = 6'd27,
                           OP_TEQ   = 6'd28, OP_ADDI  = 6'd29, OP_ADDIU   = 6'd30, OP_ANDI  = 6'd31,
                           OP_ORI   = 6'd32, OP_XORI  = 6'd33, OP_SLTI    = 6'd34, OP_SLTIU = 6'd35,
                           OP_LUI   = 6'd36, OP_BEQ   = 6'd37, OP_BNE     = 6'd38, OP_J     = 6'd39,
                           OP_JAL   = 6'd40, OP_LW    = 6'd41, OP_SW      = 6'd42, OP_LB    = 6'd43,
                           OP_LBU   = 6'd44, OP_LH    = 6'd45, OP_LHU     = 6'd46, OP_SB    = 6'd47,
                           OP_SH    = 6'd48, OP_BGEZ  = 6'd49, OP_MFC0    = 6'd50, OP_MTC0  = 6'd51,
                           OP_ERET  = 6'd52, OP_CLZ   = 6'd53, OP_MUL     = 6'd54;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000, OPC_REGIMM = 6'b000001, OPC_COP0 = 6'b010000,
                           OPC_SPECIAL2 = 6'b011100,
                           OPC_ADDI = 6'b001000, OPC_ADDIU = 6'b001001, OPC_ANDI = 6'b001100,
                           OPC_ORI  = 6'b001101, OPC_XORI  = 6'b001110, OPC_SLTI = 6'b001010,
                           OPC_SLTIU = 6'b001011, OPC_LUI  = 6'b001111, OPC_BEQ  = 6'b000100,
                           OPC_BNE  = 6'b000101, OPC_J     = 6'b000010, OPC_JAL  = 6'b000011,
                           OPC_LW   = 6'b100011, OPC_SW    = 6'b101011, OPC_LB   = 6'b100000,
                           OPC_LBU  = 6'b100100, OPC_LH    = 6'b100001, OPC_LHU  = 6'b100101,
                           OPC_SB   = 6'b101000, OPC_SH    = 6'b101001;

    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010,
                           F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR   = 6'b100101,
                           F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010,
                           F_SLTU = 6'b101011, F_SLL  = 6'b000000, F_SRL  = 6'b000010,
                           F_SRA  = 6'b000011, F_SLLV = 6'b000100, F_SRLV = 6'b000110,
                           F_SRAV = 6'b000111, F_JR   = 6'b001000, F_JALR = 6'b001001,
                           F_SYSCALL = 6'b001100, F_BREAK = 6'b001101, F_MFHI = 6'b010000,
                           F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011,
                           F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                           F_DIVU = 6'b011011, F_TEQ  = 6'b110100,
                           F_COP0_MOV = 6'b000000, F_ERET = 6'b011000,
                           F2_CLZ = 6'b100000, F2_MUL = 6'b000010;

    localparam logic [4:0] RT_BGEZ = 5'b00001, RS_MFC0 = 5'b00000, RS_MTC0 = 5'b00100,
                           RS_ERET = 5'b10000;

    typedef struct packed {
        logic [NUM_OPS-1:0] op;
        logic               illegal;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic [4:0]         shamt;
        logic [31:0]        imm_s;
        logic [31:0]        imm_z;
        logic [25:0]        jidx;
        logic [31:0]        pc;
    } entry_t;

endpackage

// File: rtl/instr_decode_core.sv
// Pure combinational decode of one instruction word into a one-hot op, an illegal flag
// and the extracted register/immediate fields.
module instr_decode_core
    import instr_pkg::*;
(
    input  logic [31:0]        instr,
    output logic [NUM_OPS-1:0] op,
    output logic               illegal,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [31:0]        imm_s,
    output logic [31:0]        imm_z,
    output logic [25:0]        jidx
);

    logic [5:0] opc;
    logic [5:0] funct;
    logic [5:0] sel;
    logic       hit;

    assign opc   = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_z = {16'h0000, instr[15:0]};
    assign jidx  = instr[25:0];

    always_comb begin
        hit = 1'b1;
        sel = OP_ADD;
        case (opc)
            OPC_SPECIAL: begin
                case (funct)
                    F_ADD:     sel = OP_ADD;     F_ADDU:  sel = OP_ADDU;
                    F_SUB:     sel = OP_SUB;     F_SUBU:  sel = OP_SUBU;
                    F_AND:     sel = OP_AND;     F_OR:    sel = OP_OR;
                    F_XOR:     sel = OP_XOR;     F_NOR:   sel = OP_NOR;
                    F_SLT:     sel = OP_SLT;     F_SLTU:  sel = OP_SLTU;
                    F_SLL:     sel = OP_SLL;     F_SRL:   sel = OP_SRL;
                    F_SRA:     sel = OP_SRA;     F_SLLV:  sel = OP_SLLV;
                    F_SRLV:    sel = OP_SRLV;    F_SRAV:  sel = OP_SRAV;
                    F_JR:      sel = OP_JR;      F_JALR:  sel = OP_JALR;
                    F_SYSCALL: sel = OP_SYSCALL; F_BREAK: sel = OP_BREAK;
                    F_MFHI:    sel = OP_MFHI;    F_MTHI:  sel = OP_MTHI;
                    F_MFLO:    sel = OP_MFLO;    F_MTLO:  sel = OP_MTLO;
                    F_MULT:    sel = OP_MULT;    F_MULTU: sel = OP_MULTU;
                    F_DIV:     sel = OP_DIV;     F_DIVU:  sel = OP_DIVU;
                    F_TEQ:     sel = OP_TEQ;
                    default:   hit = 1'b0;
                endcase
            end
            OPC_REGIMM: begin
                if (rt == RT_BGEZ) sel = OP_BGEZ;
                else               hit = 1'b0;
            end
            OPC_COP0: begin
                if (rs == RS_MFC0 && funct == F_COP0_MOV)      sel = OP_MFC0;
                else if (rs == RS_MTC0 && funct == F_COP0_MOV) sel = OP_MTC0;
                else if (rs == RS_ERET && funct == F_ERET)     sel = OP_ERET;
                else                                           hit = 1'b0;
            end
            OPC_SPECIAL2: begin
                if (funct == F2_CLZ)      sel = OP_CLZ;
                else if (funct == F2_MUL) sel = OP_MUL;
                else                      hit = 1'b0;
            end
            OPC_ADDI:  sel = OP_ADDI;  OPC_ADDIU: sel = OP_ADDIU;
            OPC_ANDI:  sel = OP_ANDI;  OPC_ORI:   sel = OP_ORI;
            OPC_XORI:  sel = OP_XORI;  OPC_SLTI:  sel = OP_SLTI;
            OPC_SLTIU: sel = OP_SLTIU; OPC_LUI:   sel = OP_LUI;
            OPC_BEQ:   sel = OP_BEQ;   OPC_BNE:   sel = OP_BNE;
            OPC_J:     sel = OP_J;     OPC_JAL:   sel = OP_JAL;
            OPC_LW:    sel = OP_LW;    OPC_SW:    sel = OP_SW;
            OPC_LB:    sel = OP_LB;    OPC_LBU:   sel = OP_LBU;
            OPC_LH:    sel = OP_LH;    OPC_LHU:   sel = OP_LHU;
            OPC_SB:    sel = OP_SB;    OPC_SH:    sel = OP_SH;
            default:   hit = 1'b0;
        endcase
        op      = hit ? (NUM_OPS'(1) << sel) : '0;
        illegal = !hit;
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered instruction decoder: decodes each accepted fetch word and queues the result
// in a small ring buffer with valid/ready on both sides, counting illegal encodings.
module instr_decode_pipe
    import instr_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OPS-1:0] out_op,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [31:0]        out_imm_s,
    output logic [31:0]        out_imm_z,
    output logic [25:0]        out_jidx,
    output logic [31:0]        out_pc,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam int PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_BITS = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(BUF_DEPTH);

    entry_t              fifo_q [BUF_DEPTH];
    entry_t              fifo_d [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [CNT_W-1:0]    illegal_cnt_q, illegal_cnt_d;
    entry_t              new_entry;
    entry_t              head;
    logic                push;
    logic                pop;

    instr_decode_core u_core (
        .instr   (in_instr),
        .op      (new_entry.op),
        .illegal (new_entry.illegal),
        .rs      (new_entry.rs),
        .rt      (new_entry.rt),
        .rd      (new_entry.rd),
        .shamt   (new_entry.shamt),
        .imm_s   (new_entry.imm_s),
        .imm_z   (new_entry.imm_z),
        .jidx    (new_entry.jidx)
    );
    assign new_entry.pc = in_pc;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = !rst && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = new_entry;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                if (new_entry.illegal && illegal_cnt_q != '1) begin
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_BITS'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            illegal_cnt_q <= '0;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign head        = fifo_q[rd_ptr_q];
    assign out_op      = head.op;
    assign out_illegal = head.illegal;
    assign out_rs      = head.rs;
    assign out_rt      = head.rt;
    assign out_rd      = head.rd;
    assign out_shamt   = head.shamt;
    assign out_imm_s   = head.imm_s;
    assign out_imm_z   = head.imm_z;
    assign out_jidx    = head.jidx;
    assign out_pc      = head.pc;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed bench for instr_decode_pipe; a second instance with a 2-bit counter shares the
// same stimulus so that counter saturation can be observed.
module tb_instr_decode_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [54:0] out_op;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [31:0] out_imm_s, out_imm_z, out_pc;
    logic [25:0] out_jidx;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    logic        s_in_ready, s_out_valid, s_out_illegal;
    logic [54:0] s_out_op;
    logic [4:0]  s_out_rs, s_out_rt, s_out_rd, s_out_shamt;
    logic [31:0] s_out_imm_s, s_out_imm_z, s_out_pc;
    logic [25:0] s_out_jidx;
    logic [1:0]  s_illegal_cnt;

    int total;
    int bad;

    instr_decode_pipe #(.BUF_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_imm_s(out_imm_s), .out_imm_z(out_imm_z),
        .out_jidx(out_jidx), .out_pc(out_pc), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    instr_decode_pipe #(.BUF_DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_op(s_out_op), .out_rs(s_out_rs), .out_rt(s_out_rt), .out_rd(s_out_rd),
        .out_shamt(s_out_shamt), .out_imm_s(s_out_imm_s), .out_imm_z(s_out_imm_z),
        .out_jidx(s_out_jidx), .out_pc(s_out_pc), .out_illegal(s_out_illegal),
        .illegal_cnt(s_illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [54:0] onehot(input int idx);
        return 55'(1) << idx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready_in_rst: got %b want 0", in_ready); end
        total++; if (out_op !== 55'd0) begin bad++; $display("[TB] FAIL reset_out_op: got %h want 0", out_op); end
        total++; if (out_pc !== 32'd0) begin bad++; $display("[TB] FAIL reset_out_pc: got %h want 0", out_pc); end
        total++; if (illegal_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", illegal_cnt); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFC000000;
        in_pc     = 32'h0000_0040;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL illegal_valid_%0d: got %b want 1", i, out_valid); end
            total++; if (out_illegal !== 1'b1) begin bad++; $display("[TB] FAIL illegal_flag_%0d: got %b want 1", i, out_illegal); end
            total++; if (out_op !== 55'd0) begin bad++; $display("[TB] FAIL illegal_op_%0d: got %h want 0", i, out_op); end
            total++; if (illegal_cnt !== 16'(i)) begin bad++; $display("[TB] FAIL illegal_cnt_%0d: got %0d want %0d", i, illegal_cnt, i); end
            total++; if (s_illegal_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin bad++; $display("[TB] FAIL sat_cnt_%0d: got %0d want %0d", i, s_illegal_cnt, (i > 3) ? 3 : i); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL illegal_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00221820;
        in_pc     = 32'h0000_0100;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid: got %b want 1", out_valid); end
        total++; if (out_op !== onehot(0)) begin bad++; $display("[TB] FAIL add_op: got %h want %h", out_op, onehot(0)); end
        total++; if ({out_rs, out_rt, out_rd, out_shamt} !== {5'd1, 5'd2, 5'd3, 5'd0}) begin bad++; $display("[TB] FAIL add_regs: got rs=%0d rt=%0d rd=%0d sh=%0d want 1 2 3 0", out_rs, out_rt, out_rd, out_shamt); end
        total++; if (out_pc !== 32'h0000_0100) begin bad++; $display("[TB] FAIL add_pc: got %h want 00000100", out_pc); end
        total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL add_illegal: got %b want 0", out_illegal); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_popped: got %b want 0", out_valid); end
    endtask

    task automatic test_addiu();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h2401FFFF;
        in_pc     = 32'h0000_0104;
        tick();
        in_valid = 1'b0;
        total++; if (out_op !== onehot(30)) begin bad++; $display("[TB] FAIL addiu_op: got %h want %h", out_op, onehot(30)); end
        total++; if (out_imm_s !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL addiu_imm_s: got %h want ffffffff", out_imm_s); end
        total++; if (out_imm_z !== 32'h0000FFFF) begin bad++; $display("[TB] FAIL addiu_imm_z: got %h want 0000ffff", out_imm_z); end
        total++; if (out_jidx !== 26'h001FFFF) begin bad++; $display("[TB] FAIL addiu_jidx: got %h want 001ffff", out_jidx); end
        total++; if (out_rt !== 5'd1) begin bad++; $display("[TB] FAIL addiu_rt: got %0d want 1", out_rt); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [8] = '{32'h40806000, 32'h42000018, 32'h00000018, 32'h70000002,
                                   32'h04010004, 32'h00000000, 32'h04000000, 32'h40000001};
        int          idx   [8] = '{51, 52, 24, 54, 49, 10, -1, -1};
        logic [54:0] exp_op;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instr = words[i];
            in_pc    = 32'h200 + 32'(4 * i);
            tick();
            exp_op = (idx[i] < 0) ? 55'd0 : onehot(idx[i]);
            total++; if (out_op !== exp_op) begin bad++; $display("[TB] FAIL b2b_op_%0d: got %h want %h", i, out_op, exp_op); end
            total++; if (out_illegal !== (idx[i] < 0)) begin bad++; $display("[TB] FAIL b2b_illegal_%0d: got %b want %b", i, out_illegal, idx[i] < 0); end
            total++; if (out_pc !== 32'h200 + 32'(4 * i)) begin bad++; $display("[TB] FAIL b2b_pc_%0d: got %h want %h", i, out_pc, 32'h200 + 32'(4 * i)); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got %b want 0", out_valid); end
        total++; if (illegal_cnt !== 16'd6) begin bad++; $display("[TB] FAIL b2b_cnt: got %0d want 6", illegal_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00221820; in_pc = 32'h300;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_1: got %b want 1", in_ready); end
        in_instr  = 32'h2401FFFF; in_pc = 32'h304;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_full: got %b want 0", in_ready); end
        in_instr  = 32'h70000002; in_pc = 32'h308;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_still_full: got %b want 0", in_ready); end
        total++; if (out_op !== onehot(0) || out_pc !== 32'h300) begin bad++; $display("[TB] FAIL bp_head_stable: got op=%h pc=%h want op=%h pc=00000300", out_op, out_pc, onehot(0)); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_op !== onehot(30) || out_pc !== 32'h304) begin bad++; $display("[TB] FAIL bp_drain_2nd: got v=%b op=%h pc=%h want v=1 op=%h pc=00000304", out_valid, out_op, out_pc, onehot(30)); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_third_dropped: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00221820; in_pc = 32'h400;
        tick();
        in_pc = 32'h404;
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'hFC000000; in_pc = 32'h408;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_empty: got %b want 1", in_ready); end
        total++; if (illegal_cnt !== 16'd6) begin bad++; $display("[TB] FAIL flush_cnt: got %0d want 6", illegal_cnt); end
        in_valid = 1'b1;
        in_instr = 32'h2401FFFF; in_pc = 32'h40C;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_op !== onehot(30) || out_pc !== 32'h40C) begin bad++; $display("[TB] FAIL flush_refill: got v=%b op=%h pc=%h want v=1 op=%h pc=0000040c", out_valid, out_op, out_pc, onehot(30)); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFC000000; in_pc = 32'h500;
        tick();
        tick();
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid: got %b want 0", out_valid); end
        total++; if (illegal_cnt !== 16'd0 || s_illegal_cnt !== 2'd0) begin bad++; $display("[TB] FAIL rstmid_cnt: got %0d/%0d want 0/0", illegal_cnt, s_illegal_cnt); end
        total++; if (out_op !== 55'd0 || out_illegal !== 1'b0 || out_pc !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_data: got op=%h ill=%b pc=%h want zeros", out_op, out_illegal, out_pc); end
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_illegal();
        test_add();
        test_addiu();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
